// File: rtl/alu_div_sequencer.sv
// -----------------------------------------------------------------------------
// alu_div_sequencer
//
// Multi-cycle restoring divider that borrows the shared 32-bit EX-stage ALU.
// Each cycle it issues one ALU operation (SUB or RSB) and consumes the result.
// While it runs, it holds the pipeline in a stall. It returns the quotient and
// remainder with a one-cycle done pulse. Signed divides are done as unsigned
// divides on the operand magnitudes, with sign fix-ups at the end.
//
// Ports
//   clk, reset        : single clock, synchronous active-high reset
//   start             : request, sampled only while idle
//   flush             : abandons any operation in flight (except the DONE cycle)
//   is_signed         : 1 = two's-complement divide, 0 = unsigned
//   dividend, divisor : operands, captured with an accepted start
//   alu_a, alu_b      : ALU operands driven while alu_own is high (else 0)
//   alu_ctrl          : ALU control, SUB = 5'b00001 (a-b), RSB = 5'b01000 (b-a)
//   alu_result        : combinational ALU result
//   alu_flags         : {N,Z,C,V}; C (bit 1) = 1 on SUB means no borrow
//   alu_own           : sequencer owns the ALU operand/control mux
//   busy              : stall request, high in every state except IDLE
//   done              : one-cycle pulse, quotient/remainder valid
//   quotient          : registered result, held until the next accepted start
//   remainder         : registered result, held until the next accepted start
// -----------------------------------------------------------------------------
module alu_div_sequencer #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        alu_own,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam logic [4:0] ALU_SUB   = 5'b00001;
  localparam logic [4:0] ALU_RSB   = 5'b01000;
  localparam logic [4:0] CNT_START = 5'(DIV_ITERS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NEG_N = 3'd1,
    NEG_D = 3'd2,
    ITER  = 3'd3,
    FIX_Q = 3'd4,
    FIX_R = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_r;          // partial remainder
  logic [31:0] r_q;          // dividend shifting out / quotient shifting in
  logic [31:0] r_d;          // divisor (magnitude for signed ops)
  logic [4:0]  r_cnt;
  logic        r_signed;
  logic        r_sq;         // quotient must be negated at the end
  logic        r_sr;         // remainder must be negated at the end

  logic [31:0] w_shifted;
  logic        w_take;
  logic [31:0] w_r_iter;
  logic [31:0] w_q_iter;
  logic        w_accept;
  logic        w_unused_flags;

  // Only the carry flag matters to the divide.
  assign w_unused_flags = ^{alu_flags[3:2], alu_flags[0]};

  assign w_accept  = start & ~flush;

  // One restoring step: shift the next dividend bit into the remainder and
  // try to subtract the divisor. If R[31] was set before the shift, the
  // shifted value is really 33 bits wide and certainly >= D, so the
  // subtraction is taken no matter what the 32-bit borrow says.
  assign w_shifted = {r_r[30:0], r_q[31]};
  assign w_take    = r_r[31] | alu_flags[1];
  assign w_r_iter  = w_take ? alu_result : w_shifted;
  assign w_q_iter  = {r_q[30:0], w_take};

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

  // Next-state and ALU drive
  always_comb begin
    w_state_nxt = r_state;
    alu_a       = '0;
    alu_b       = '0;
    alu_ctrl    = '0;
    alu_own     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (divisor == 32'd0)  w_state_nxt = DONE;
          else if (is_signed)    w_state_nxt = NEG_N;
          else                   w_state_nxt = ITER;
        end
      end
      NEG_N: begin
        alu_own     = 1'b1;
        alu_a       = r_q;
        alu_ctrl    = ALU_RSB;
        w_state_nxt = flush ? IDLE : NEG_D;
      end
      NEG_D: begin
        alu_own     = 1'b1;
        alu_a       = r_d;
        alu_ctrl    = ALU_RSB;
        w_state_nxt = flush ? IDLE : ITER;
      end
      ITER: begin
        alu_own  = 1'b1;
        alu_a    = w_shifted;
        alu_b    = r_d;
        alu_ctrl = ALU_SUB;
        if (flush)                 w_state_nxt = IDLE;
        else if (r_cnt == 5'd0)    w_state_nxt = r_signed ? FIX_Q : DONE;
      end
      FIX_Q: begin
        alu_own     = 1'b1;
        alu_a       = r_q;
        alu_ctrl    = ALU_RSB;
        w_state_nxt = flush ? IDLE : FIX_R;
      end
      FIX_R: begin
        alu_own     = 1'b1;
        alu_a       = r_r;
        alu_ctrl    = ALU_RSB;
        w_state_nxt = flush ? IDLE : DONE;
      end
      DONE:    w_state_nxt = IDLE;   // completes even under flush
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_r       <= '0;
      r_q       <= '0;
      r_d       <= '0;
      r_cnt     <= '0;
      r_signed  <= 1'b0;
      r_sq      <= 1'b0;
      r_sr      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_q      <= dividend;
            r_d      <= divisor;
            r_r      <= '0;
            r_cnt    <= CNT_START;
            r_signed <= is_signed;
            r_sq     <= is_signed & (dividend[31] ^ divisor[31]);
            r_sr     <= is_signed & dividend[31];
            // Divide by zero bypasses the ALU entirely.
            if (divisor == 32'd0) begin
              quotient  <= 32'hFFFF_FFFF;
              remainder <= dividend;
            end
          end
        end
        NEG_N: begin
          if (!flush && r_q[31]) r_q <= alu_result;
        end
        NEG_D: begin
          if (!flush && r_d[31]) r_d <= alu_result;
        end
        ITER: begin
          if (!flush) begin
            r_r   <= w_r_iter;
            r_q   <= w_q_iter;
            r_cnt <= r_cnt - 5'd1;
            // Unsigned results land on entry to DONE.
            if (r_cnt == 5'd0 && !r_signed) begin
              quotient  <= w_q_iter;
              remainder <= w_r_iter;
            end
          end
        end
        FIX_Q: begin
          if (!flush && r_sq) r_q <= alu_result;
        end
        FIX_R: begin
          if (!flush) begin
            if (r_sr) r_r <= alu_result;
            quotient  <= r_q;
            remainder <= r_sr ? alu_result : r_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
module tb_alu_div_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        alu_own;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_checks = 0;
  int n_errors = 0;

  alu_div_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .flush      (flush),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .alu_own    (alu_own),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;

  // Shared EX-stage ALU model: SUB, RSB, and ADD for anything else.
  logic [32:0] t_diff;
  logic        t_c;
  always_comb begin
    t_diff     = '0;
    t_c        = 1'b0;
    alu_result = alu_a + alu_b;
    case (alu_ctrl)
      5'b00001: begin
        t_diff     = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = t_diff[31:0];
        t_c        = ~t_diff[32];
      end
      5'b01000: begin
        t_diff     = {1'b0, alu_b} - {1'b0, alu_a};
        alu_result = t_diff[31:0];
        t_c        = ~t_diff[32];
      end
      default: ;
    endcase
    alu_flags = {alu_result[31], (alu_result == 32'd0), t_c, 1'b0};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Called at a negedge: drives start now, then follows the operation to done.
  task automatic run_vec(input string nm, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input int lat);
    int  k      = 0;
    int  own_n  = 0;
    int  busy_n = 0;
    bit  seen   = 1'b0;
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    while (!seen && k < 60) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (busy)    busy_n++;
      if (alu_own) own_n++;
      if (done)    seen = 1'b1;
    end
    chk({nm, " done_seen"}, 32'(seen), 32'd1);
    chk({nm, " latency"},   32'(k), 32'(lat));
    chk({nm, " quotient"},  quotient, eq);
    chk({nm, " remainder"}, remainder, er);
    chk({nm, " busy_cycles"}, 32'(busy_n), 32'(lat));
    chk({nm, " own_cycles"},  32'(own_n), (lat == 1) ? 32'd0 : 32'(lat - 1));
    @(negedge clk);
    chk({nm, " busy_after"}, 32'(busy), 32'd0);
    chk({nm, " done_after"}, 32'(done), 32'd0);
  endtask

  typedef struct {
    string       nm;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vt[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  bad;

    vt[0]  = '{"u100_7",     1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         33};
    vt[1]  = '{"u_msb",      1'b0, 32'hFFFFFFFF,  32'h80000001,  32'd1,         32'h7FFFFFFE,  33};
    vt[2]  = '{"s_m7_2",     1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  37};
    vt[3]  = '{"s_min_m1",   1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         37};
    vt[4]  = '{"u_div0",     1'b0, 32'h1234,      32'd0,         32'hFFFFFFFF,  32'h1234,      1};
    vt[5]  = '{"s_div0",     1'b1, 32'h1234,      32'd0,         32'hFFFFFFFF,  32'h1234,      1};
    vt[6]  = '{"s_7_m2",     1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         37};
    vt[7]  = '{"s_m7_m2",    1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  37};
    vt[8]  = '{"u5_10",      1'b0, 32'd5,         32'd10,        32'd0,         32'd5,         33};
    vt[9]  = '{"u_max_1",    1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         33};
    vt[10] = '{"s100_7",     1'b1, 32'd100,       32'd7,         32'd14,        32'd2,         37};
    vt[11] = '{"u_min_3",    1'b0, 32'h80000000,  32'd3,         32'h2AAAAAAA,  32'd2,         33};

    reset = 1'b1; start = 1'b0; flush = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst busy",      32'(busy), 32'd0);
    chk("rst done",      32'(done), 32'd0);
    chk("rst own",       32'(alu_own), 32'd0);
    chk("rst alu_a",     alu_a, 32'd0);
    chk("rst alu_ctrl",  32'(alu_ctrl), 32'd0);
    chk("rst quotient",  quotient, 32'd0);
    chk("rst remainder", remainder, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_vec(vt[i].nm, vt[i].sg, vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].lat);

    // A start pulsed mid-operation is ignored and not queued.
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    k = 0; bad = 1'b0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (k == 10) begin
        start = 1'b1; is_signed = 1'b1; dividend = 32'd50; divisor = 32'd5;
      end
    end
    start = 1'b0;
    chk("ign latency",   32'(k), 32'd33);
    chk("ign quotient",  quotient, 32'd14);
    chk("ign remainder", remainder, 32'd2);
    @(negedge clk);
    chk("ign no_queue busy", 32'(busy), 32'd0);

    // Flush in cycle 20: abandon, no done, previous results held.
    is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    bad = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) bad = 1'b1;
      if (c == 20) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    chk("flush no_done",   32'(bad), 32'd0);
    chk("flush busy",      32'(busy), 32'd0);
    chk("flush done",      32'(done), 32'd0);
    chk("flush quotient",  quotient, 32'd14);
    chk("flush remainder", remainder, 32'd2);
    run_vec("after_flush", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33);

    // Flush in IDLE wins over a simultaneous start.
    start = 1'b1; flush = 1'b1; dividend = 32'd9; divisor = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle_flush busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("idle_flush done", 32'(done), 32'd0);
    chk("idle_flush quotient", quotient, 32'd333);

    // Reset in cycle 15 of a running signed divide.
    is_signed = 1'b1; dividend = 32'hFFFFFFF9; divisor = 32'd2; start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 15) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    chk("midrst busy",      32'(busy), 32'd0);
    chk("midrst done",      32'(done), 32'd0);
    chk("midrst own",       32'(alu_own), 32'd0);
    chk("midrst alu_a",     alu_a, 32'd0);
    chk("midrst alu_b",     alu_b, 32'd0);
    chk("midrst alu_ctrl",  32'(alu_ctrl), 32'd0);
    chk("midrst quotient",  quotient, 32'd0);
    chk("midrst remainder", remainder, 32'd0);
    run_vec("after_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
